// File: rtl/cdc_handshake_tx.sv
// Source (transmit) half of a toggle req/ack CDC handshake for a multi-bit word.
// Holds one captured word on TX_DATA, flips REQ_TOGGLE, then waits for the resynchronised ACK level to match.
module cdc_handshake_tx #(
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] SRC_DATA,
    input  logic                 SRC_VALID,
    output logic                 SRC_READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 REQ_TOGGLE,
    input  logic                 ACK_ASYNC,
    output logic                 BUSY,
    output logic                 TIMEOUT_ERR,
    output logic                 PROTO_ERR
);

    localparam int unsigned      CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_s;
    logic                   ready_q, ready_d;
    logic [BUS_WIDTH-1:0]   data_q, data_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tmo_q, tmo_d;
    logic                   proto_q, proto_d;

    // ACK is a level from another clock domain; only the last stage is used.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ACK_ASYNC};
        end
    end

    assign ack_s = ack_sync_q[NUM_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            proto_q <= proto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        data_d  = data_q;
        req_d   = req_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        proto_d = proto_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                // With nothing outstanding the synchronised ACK must already match REQ.
                if (ack_s != req_q) begin
                    proto_d = 1'b1;
                end
                if (SRC_VALID && ready_q) begin
                    data_d  = SRC_DATA;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                req_d   = ~req_q;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s == req_q) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if ((TIMEOUT_CYCLES != 0) && (cnt_d == CNT_MAX)) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SRC_READY   = ready_q;
    assign TX_DATA     = data_q;
    assign REQ_TOGGLE  = req_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = tmo_q;
    assign PROTO_ERR   = proto_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: scenario tasks with a word scoreboard
// matched against the TX_DATA value seen at every REQ_TOGGLE edge.
module tb_cdc_handshake_tx;

    localparam int unsigned BW  = 8;
    localparam int unsigned NS  = 2;
    localparam int unsigned TMO = 10;

    logic          CLK = 1'b0;
    logic          RST;
    logic [BW-1:0] SRC_DATA;
    logic          SRC_VALID;
    logic          SRC_READY;
    logic [BW-1:0] TX_DATA;
    logic          REQ_TOGGLE;
    logic          ACK_ASYNC;
    logic          BUSY;
    logic          TIMEOUT_ERR;
    logic          PROTO_ERR;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] sb[$];
    logic [BW-1:0] obs_data[$];
    logic          obs_req[$];
    logic          req_prev = 1'b0;

    cdc_handshake_tx #(
        .BUS_WIDTH     (BW),
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SRC_DATA   (SRC_DATA),
        .SRC_VALID  (SRC_VALID),
        .SRC_READY  (SRC_READY),
        .TX_DATA    (TX_DATA),
        .REQ_TOGGLE (REQ_TOGGLE),
        .ACK_ASYNC  (ACK_ASYNC),
        .BUSY       (BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .PROTO_ERR  (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance to the next falling edge and log any REQ_TOGGLE edge with the word it presents.
    task automatic cyc();
        @(negedge CLK);
        if (REQ_TOGGLE !== req_prev) begin
            obs_data.push_back(TX_DATA);
            obs_req.push_back(REQ_TOGGLE);
            req_prev = REQ_TOGGLE;
        end
    endtask

    task automatic clear_logs();
        sb.delete();
        obs_data.delete();
        obs_req.delete();
        req_prev = REQ_TOGGLE;
    endtask

    task automatic test_reset();
        RST = 1'b0; SRC_VALID = 1'b0; SRC_DATA = '0; ACK_ASYNC = 1'b0;
        cyc(); cyc();
        checks++; if (SRC_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", SRC_READY); end
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", TX_DATA); end
        checks++; if (REQ_TOGGLE !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", REQ_TOGGLE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", TIMEOUT_ERR); end
        checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL rst_proto got %b exp 0", PROTO_ERR); end
        RST = 1'b1;
        clear_logs();
        cyc();
        checks++; if (SRC_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", SRC_READY); end
    endtask

    task automatic test_basic();
        logic [BW-1:0] e, g;
        SRC_VALID = 1'b1; SRC_DATA = 8'hA5; sb.push_back(8'hA5);
        cyc();
        SRC_VALID = 1'b0; SRC_DATA = 8'h00;
        checks++; if (TX_DATA !== 8'hA5) begin errors++; $display("FAIL basic_tx got %h exp a5", TX_DATA); end
        checks++; if (SRC_READY !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b exp 0", SRC_READY); end
        checks++; if (REQ_TOGGLE !== 1'b0) begin errors++; $display("FAIL basic_req_early got %b exp 0", REQ_TOGGLE); end
        cyc();
        checks++; if (REQ_TOGGLE !== 1'b1) begin errors++; $display("FAIL basic_req_rise got %b exp 1", REQ_TOGGLE); end
        cyc(); cyc();
        ACK_ASYNC = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++; if (SRC_READY !== (k == 3)) begin errors++; $display("FAIL basic_ready k=%0d got %b exp %b", k, SRC_READY, (k == 3)); end
            checks++; if (BUSY !== (k != 3)) begin errors++; $display("FAIL basic_busy k=%0d got %b exp %b", k, BUSY, (k != 3)); end
        end
        checks++; if (obs_data.size() != sb.size()) begin errors++; $display("FAIL basic_sb_count got %0d exp %0d", obs_data.size(), sb.size()); end
        while (sb.size() > 0 && obs_data.size() > 0) begin
            e = sb.pop_front(); g = obs_data.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL basic_sb_word got %h exp %h", g, e); end
        end
    endtask

    task automatic test_mid_reset();
        logic [BW-1:0] e, g;
        RST = 1'b0; ACK_ASYNC = 1'b0;
        cyc();
        RST = 1'b1;
        clear_logs();
        cyc();
        SRC_VALID = 1'b1; SRC_DATA = 8'h3C; sb.push_back(8'h3C);
        cyc();
        SRC_VALID = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (REQ_TOGGLE !== 1'b1) begin errors++; $display("FAIL midrst_req_pre got %b exp 1", REQ_TOGGLE); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre got %b exp 1", BUSY); end
        checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL midrst_sb_count got %0d exp 1", obs_data.size()); end
        if (obs_data.size() > 0) begin
            e = sb.pop_front(); g = obs_data.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL midrst_sb_word got %h exp %h", g, e); end
        end
        RST = 1'b0;
        cyc();
        checks++; if (REQ_TOGGLE !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", REQ_TOGGLE); end
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL midrst_tx got %h exp 00", TX_DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", BUSY); end
        checks++; if (SRC_READY !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", SRC_READY); end
        RST = 1'b1;
        clear_logs();
        cyc();
        checks++; if (SRC_READY !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got %b exp 1", SRC_READY); end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] w [3];
        logic [BW-1:0] exp_tx, e, g;
        int            acc_t [3];
        int            t, idx;
        bit            acc;
        logic          exp_req;
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
        exp_tx = 8'h00; t = 0; idx = 0;
        SRC_VALID = 1'b1; SRC_DATA = w[0];
        while (idx < 3 && t < 60) begin
            acc = (SRC_READY === 1'b1);
            if (acc) begin
                sb.push_back(w[idx]); acc_t[idx] = t; exp_tx = w[idx];
            end
            cyc(); t++;
            checks++; if (TX_DATA !== exp_tx) begin errors++; $display("FAIL b2b_tx t=%0d got %h exp %h", t, TX_DATA, exp_tx); end
            if (acc) begin
                idx++;
                if (idx < 3) SRC_DATA = w[idx]; else SRC_VALID = 1'b0;
            end
            if (REQ_TOGGLE !== ACK_ASYNC) ACK_ASYNC = REQ_TOGGLE;
        end
        SRC_VALID = 1'b0;
        checks++; if (idx != 3) begin errors++; $display("FAIL b2b_accept_budget got %0d exp 3", idx); end
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++; if (TX_DATA !== exp_tx) begin errors++; $display("FAIL b2b_tx_tail got %h exp %h", TX_DATA, exp_tx); end
            if (REQ_TOGGLE !== ACK_ASYNC) ACK_ASYNC = REQ_TOGGLE;
        end
        if (idx == 3) begin
            for (int i = 1; i < 3; i++) begin
                checks++; if (acc_t[i] - acc_t[i-1] != 3 + NS) begin errors++; $display("FAIL b2b_spacing i=%0d got %0d exp %0d", i, acc_t[i] - acc_t[i-1], 3 + NS); end
            end
        end
        checks++; if (SRC_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b busy=%b exp ready=1 busy=0", SRC_READY, BUSY); end
        checks++; if (obs_req.size() != 3) begin errors++; $display("FAIL b2b_req_count got %0d exp 3", obs_req.size()); end
        exp_req = 1'b1;
        while (obs_req.size() > 0) begin
            g[0] = obs_req.pop_front();
            checks++; if (g[0] !== exp_req) begin errors++; $display("FAIL b2b_req_seq got %b exp %b", g[0], exp_req); end
            exp_req = ~exp_req;
        end
        checks++; if (obs_data.size() != sb.size()) begin errors++; $display("FAIL b2b_sb_count got %0d exp %0d", obs_data.size(), sb.size()); end
        while (sb.size() > 0 && obs_data.size() > 0) begin
            e = sb.pop_front(); g = obs_data.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_sb_word got %h exp %h", g, e); end
        end
        sb.delete(); obs_data.delete();
    endtask

    task automatic test_glitch();
        logic [BW-1:0] e, g;
        SRC_VALID = 1'b1; SRC_DATA = 8'h77; sb.push_back(8'h77);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            SRC_VALID = 1'(k % 2); SRC_DATA = 8'hEE;
            cyc();
            checks++; if (TX_DATA !== 8'h77) begin errors++; $display("FAIL glitch_tx k=%0d got %h exp 77", k, TX_DATA); end
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL glitch_busy k=%0d got %b exp 1", k, BUSY); end
        end
        SRC_VALID = 1'b0;
        ACK_ASYNC = ~ACK_ASYNC;
        cyc(); cyc(); cyc();
        checks++; if (SRC_READY !== 1'b1) begin errors++; $display("FAIL glitch_ready got %b exp 1", SRC_READY); end
        checks++; if (REQ_TOGGLE !== 1'b0) begin errors++; $display("FAIL glitch_req got %b exp 0", REQ_TOGGLE); end
        checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL glitch_req_edges got %0d exp 1", obs_data.size()); end
        while (sb.size() > 0 && obs_data.size() > 0) begin
            e = sb.pop_front(); g = obs_data.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL glitch_sb_word got %h exp %h", g, e); end
        end
        clear_logs();
    endtask

    task automatic test_proto();
        ACK_ASYNC = 1'b1;
        for (int k = 1; k <= NS + 1; k++) begin
            cyc();
            checks++; if (PROTO_ERR !== (k == NS + 1)) begin errors++; $display("FAIL proto_flag k=%0d got %b exp %b", k, PROTO_ERR, (k == NS + 1)); end
            checks++; if (SRC_READY !== 1'b1) begin errors++; $display("FAIL proto_ready k=%0d got %b exp 1", k, SRC_READY); end
        end
        ACK_ASYNC = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (PROTO_ERR !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", PROTO_ERR); end
        checks++; if (REQ_TOGGLE !== 1'b0 || obs_req.size() != 0) begin errors++; $display("FAIL proto_req got %b edges %0d exp 0 edges 0", REQ_TOGGLE, obs_req.size()); end
        clear_logs();
    endtask

    task automatic test_timeout();
        logic [BW-1:0] e, g;
        SRC_VALID = 1'b1; SRC_DATA = 8'h99; sb.push_back(8'h99);
        cyc();
        SRC_VALID = 1'b0;
        cyc();
        checks++; if (REQ_TOGGLE !== 1'b1) begin errors++; $display("FAIL tmo_req got %b exp 1", REQ_TOGGLE); end
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++; if (TIMEOUT_ERR !== (k >= TMO)) begin errors++; $display("FAIL tmo_flag k=%0d got %b exp %b", k, TIMEOUT_ERR, (k >= TMO)); end
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL tmo_busy k=%0d got %b exp 1", k, BUSY); end
        end
        ACK_ASYNC = 1'b1;
        for (int k = 1; k <= NS + 1; k++) begin
            cyc();
            checks++; if (SRC_READY !== (k == NS + 1)) begin errors++; $display("FAIL tmo_ready k=%0d got %b exp %b", k, SRC_READY, (k == NS + 1)); end
            checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_sticky k=%0d got %b exp 1", k, TIMEOUT_ERR); end
        end
        checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL tmo_sb_count got %0d exp 1", obs_data.size()); end
        while (sb.size() > 0 && obs_data.size() > 0) begin
            e = sb.pop_front(); g = obs_data.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL tmo_sb_word got %h exp %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_reset();
        test_back_to_back();
        test_glitch();
        test_proto();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-side (transmit) half of a 4-phase-free toggle req/ack CDC handshake for multi-bit buses.
- Captures a word from the local domain, holds it stable on TX_DATA, toggles REQ_TOGGLE, then waits for the destination's ACK toggle.
- The ACK toggle is resynchronised internally through a NUM_STAGES flop chain.
- The destination-side receiver samples TX_DATA after synchronising REQ_TOGGLE.

Parameters:
BUS_WIDTH, 8, width of transferred data word
NUM_STAGES, 2, flops in the ACK synchroniser chain (>=2)
TIMEOUT_CYCLES, 0, max cycles in WAIT_ACK before TIMEOUT_ERR sets; 0 disables the timeout

Ports:
CLK  input  1  source-domain clock
RST  input  1  synchronous reset, active-low, sampled on posedge CLK
SRC_DATA  input  BUS_WIDTH  word to transfer
SRC_VALID  input  1  SRC_DATA valid
SRC_READY  output  1  block can accept a word this cycle
TX_DATA  output  BUS_WIDTH  held word presented to the destination domain
REQ_TOGGLE  output  1  request level; each toggle signals one new word
ACK_ASYNC  input  1  ACK toggle from the destination domain (asynchronous)
BUSY  output  1  transfer in flight
TIMEOUT_ERR  output  1  sticky: ACK not seen within TIMEOUT_CYCLES
PROTO_ERR  output  1  sticky: ACK toggled with no request outstanding

Behaviour:
- All outputs are registered.
- Reset: one clock with RST=0 drives the following.
  - Outputs: SRC_READY=0, TX_DATA=0, REQ_TOGGLE=0, BUSY=0, TIMEOUT_ERR=0, PROTO_ERR=0.
  - Internal state: ACK sync chain = 0, timeout counter = 0, FSM = IDLE.
- First posedge after RST returns high: SRC_READY<=1.
- ACK sync: ack_s = last stage of the NUM_STAGES chain clocked by CLK. A request is complete when ack_s == REQ_TOGGLE.
- FSM IDLE:
  - SRC_READY=1.
  - On SRC_VALID && SRC_READY: TX_DATA<=SRC_DATA, SRC_READY<=0, BUSY<=1, go to SEND.
  - SRC_VALID low: stay in IDLE; TX_DATA keeps its last value.
- FSM SEND: exactly one cycle.
  - TX_DATA is already stable, giving one cycle of setup before the req edge.
  - REQ_TOGGLE<=~REQ_TOGGLE, counter<=0, go to WAIT_ACK.
- FSM WAIT_ACK:
  - If ack_s == REQ_TOGGLE: SRC_READY<=1, BUSY<=0, go to IDLE.
  - Otherwise counter increments, saturating at TIMEOUT_CYCLES.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, TIMEOUT_ERR<=1. The FSM stays in WAIT_ACK (no resend) and still completes normally if ACK arrives later.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- TX_DATA changes only on an accept; it is stable from SEND until the next accept.
- Latency:
  - Accept at edge N; REQ_TOGGLE toggles at edge N+1.
  - ACK toggling at edge M is visible as ack_s at edge M+NUM_STAGES.
  - SRC_READY rises at edge M+NUM_STAGES+1.
  - Minimum accept-to-accept period is 3+NUM_STAGES cycles when ACK returns immediately.
- Back-to-back: a new word can be accepted on the first cycle SRC_READY=1 after completion.
- PROTO_ERR: sets if ack_s != REQ_TOGGLE while in IDLE, i.e. a spurious ACK toggle. The FSM is unaffected.
- Both error flags clear only on reset.
- Reset mid-transfer (SEND or WAIT_ACK):
  - Everything returns to reset values, including REQ_TOGGLE=0.
  - The destination must be reset in the same reset window so its ACK level also returns to 0.
  - The in-flight word is discarded.
- SRC_VALID deasserted while SRC_READY=0: ignored; no buffering beyond the single held word.

Test Plan:
- Reset release, then SRC_VALID=1 with SRC_DATA=8'hA5; ACK_ASYNC toggles 0->1 two cycles after REQ_TOGGLE rises.
  -> TX_DATA=A5 one edge after accept; REQ_TOGGLE 0->1 at the next edge; SRC_READY=1 exactly NUM_STAGES+1 edges after the ACK edge; BUSY high throughout.
- Three back-to-back words 8'h01, 8'h02, 8'h03 with immediate ACK.
  -> REQ_TOGGLE sequence 1,0,1; TX_DATA steps 01->02->03 only on accept edges; accept spacing of 5 cycles with NUM_STAGES=2.
- TIMEOUT_CYCLES=10, ACK withheld for 20 cycles, then toggled.
  -> TIMEOUT_ERR=1 on the 10th WAIT_ACK cycle and stays 1; transfer completes after ACK; SRC_READY returns to 1.
- ACK_ASYNC toggled while IDLE with no request.
  -> PROTO_ERR=1 NUM_STAGES+1 edges later; SRC_READY stays 1; no REQ_TOGGLE change.
- RST=0 for one cycle while in WAIT_ACK with REQ_TOGGLE=1.
  -> Next edge shows REQ_TOGGLE=0, TX_DATA=0, BUSY=0, SRC_READY=0; SRC_READY=1 one cycle after release.
- Glitchy SRC_VALID (1-cycle pulses) while BUSY=1.
  -> No capture, TX_DATA unchanged, exactly one REQ_TOGGLE edge per accepted word.
